// File: rtl/first_nios2_system_sysid_checker.sv
// Boot-time sysid checker: reads the ID word (address 0) and timestamp word (address 1) over Avalon-MM and registers match status.
// Optional retry-on-mismatch is enabled by defining FIRST_NIOS2_SYSTEM_SYSID_CHECKER_RETRY_EN.
module first_nios2_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'h0,
    parameter logic [31:0] EXPECTED_TS  = 32'h0,
    parameter int          READ_LATENCY = 0,
    parameter int          TIMEOUT      = 255,
    parameter int          MAX_RETRIES  = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic [31:0] sysid_value,
    output logic [31:0] sysid_timestamp,
    output logic        id_match,
    output logic        ts_match,
    output logic        pass,
    output logic        timeout_err,
    output logic        busy,
    output logic        done
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ID   = 3'd1;
    localparam logic [2:0] S_WAIT_ID = 3'd2;
    localparam logic [2:0] S_RD_TS   = 3'd3;
    localparam logic [2:0] S_WAIT_TS = 3'd4;
    localparam logic [2:0] S_CHECK   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam bit          ZERO_LAT = (READ_LATENCY == 0);
    localparam logic [1:0]  LAT_LAST = 2'(READ_LATENCY);
    localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT);

    logic [2:0]  r_state;
    logic [15:0] r_toCnt;
    logic [1:0]  r_latCnt;
    logic        r_read;
    logic        r_addr;
    logic [31:0] r_value;
    logic [31:0] r_ts;
    logic        r_idMatch;
    logic        r_tsMatch;
    logic        r_pass;
    logic        r_toErr;
    logic        r_busy;
    logic        r_done;

    logic w_accept;
    logic w_toHit;
    logic w_latDone;
    logic w_idOk;
    logic w_tsOk;
    logic w_retry;

    assign w_accept  = r_read & ~m_waitrequest;
    // Timeout fires on the edge where the count would reach TIMEOUT, i.e. after TIMEOUT cycles without capture.
    assign w_toHit   = (({1'b0, r_toCnt} + 17'd1) == TO_LIMIT);
    assign w_latDone = (r_latCnt == LAT_LAST);
    assign w_idOk    = (r_value == EXPECTED_ID);
    assign w_tsOk    = (r_ts == EXPECTED_TS);

`ifdef FIRST_NIOS2_SYSTEM_SYSID_CHECKER_RETRY_EN
    localparam logic [15:0] RETRY_LIMIT = 16'(MAX_RETRIES);
    logic [15:0] r_retryCnt;

    assign w_retry = ~(w_idOk & w_tsOk) & ~r_toErr & (r_retryCnt < RETRY_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_retryCnt <= '0;
        end else if (r_state == S_DONE && start) begin
            r_retryCnt <= '0;
        end else if (r_state == S_CHECK && w_retry) begin
            r_retryCnt <= r_retryCnt + 16'd1;
        end
    end
`else
    assign w_retry = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_toCnt   <= '0;
            r_latCnt  <= '0;
            r_read    <= 1'b0;
            r_addr    <= 1'b0;
            r_value   <= '0;
            r_ts      <= '0;
            r_idMatch <= 1'b0;
            r_tsMatch <= 1'b0;
            r_pass    <= 1'b0;
            r_toErr   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_RD_ID;
                    r_read  <= 1'b1;
                    r_addr  <= 1'b0;
                    r_busy  <= 1'b1;
                    r_toCnt <= '0;
                end
                S_RD_ID, S_RD_TS: begin
                    if (w_accept && ZERO_LAT) begin
                        if (r_state == S_RD_ID) begin
                            r_value <= m_readdata;
                            r_state <= S_RD_TS;
                            r_addr  <= 1'b1;
                            r_toCnt <= '0;
                        end else begin
                            r_ts    <= m_readdata;
                            r_state <= S_CHECK;
                            r_read  <= 1'b0;
                        end
                    end else if (w_toHit) begin
                        r_toErr <= 1'b1;
                        r_read  <= 1'b0;
                        r_state <= S_CHECK;
                    end else begin
                        r_toCnt <= r_toCnt + 16'd1;
                        if (w_accept) begin
                            r_read   <= 1'b0;
                            r_latCnt <= 2'd1;
                            r_state  <= (r_state == S_RD_ID) ? S_WAIT_ID : S_WAIT_TS;
                        end
                    end
                end
                S_WAIT_ID, S_WAIT_TS: begin
                    if (w_latDone) begin
                        if (r_state == S_WAIT_ID) begin
                            r_value <= m_readdata;
                            r_state <= S_RD_TS;
                            r_read  <= 1'b1;
                            r_addr  <= 1'b1;
                            r_toCnt <= '0;
                        end else begin
                            r_ts    <= m_readdata;
                            r_state <= S_CHECK;
                        end
                    end else if (w_toHit) begin
                        r_toErr <= 1'b1;
                        r_state <= S_CHECK;
                    end else begin
                        r_toCnt  <= r_toCnt + 16'd1;
                        r_latCnt <= r_latCnt + 2'd1;
                    end
                end
                S_CHECK: begin
                    r_idMatch <= w_idOk;
                    r_tsMatch <= w_tsOk;
                    r_pass    <= w_idOk & w_tsOk & ~r_toErr;
                    if (w_retry) begin
                        r_state <= S_RD_ID;
                        r_read  <= 1'b1;
                        r_addr  <= 1'b0;
                        r_toCnt <= '0;
                    end else begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Captured words are kept; only the status is cleared for the rerun.
                    if (start) begin
                        r_idMatch <= 1'b0;
                        r_tsMatch <= 1'b0;
                        r_pass    <= 1'b0;
                        r_toErr   <= 1'b0;
                        r_done    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RD_ID;
                        r_read    <= 1'b1;
                        r_addr    <= 1'b0;
                        r_toCnt   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_address       = r_addr;
    assign m_read          = r_read;
    assign sysid_value     = r_value;
    assign sysid_timestamp = r_ts;
    assign id_match        = r_idMatch;
    assign ts_match        = r_tsMatch;
    assign pass            = r_pass;
    assign timeout_err     = r_toErr;
    assign busy            = r_busy;
    assign done            = r_done;
endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Self-checking bench for first_nios2_system_sysid_checker: a cycle-level sysid slave plus a timing/status reference model.
// Honours FIRST_NIOS2_SYSTEM_SYSID_CHECKER_RETRY_EN when predicting retry passes.
module tb_first_nios2_system_sysid_checker;
    localparam logic [31:0] EXP_ID = 32'h52435AF5;
    localparam logic [31:0] EXP_TS = 32'h5EC01D17;
    localparam int LAT  = 2;
    localparam int TMO  = 10;
    localparam int MAXR = 3;
`ifdef FIRST_NIOS2_SYSTEM_SYSID_CHECKER_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        m_waitrequest = 1'b0;
    logic [31:0] m_readdata = '0;
    logic        m_address, m_read;
    logic [31:0] sysid_value, sysid_timestamp;
    logic        id_match, ts_match, pass, timeout_err, busy, done;

    int nCompared = 0;
    int nMismatched = 0;

    // Reference view of the captured words, carried across runs like the hardware registers.
    logic [31:0] mdlValue = '0;
    logic [31:0] mdlTs = '0;

    int          doneEdge, pairs, viol, lastRead, expDone, expPairs;
    logic [4:0]  first;
    logic [3:0]  expStat;

    first_nios2_system_sysid_checker #(
        .EXPECTED_ID (EXP_ID),
        .EXPECTED_TS (EXP_TS),
        .READ_LATENCY(LAT),
        .TIMEOUT     (TMO),
        .MAX_RETRIES (MAXR)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .m_address      (m_address),
        .m_read         (m_read),
        .m_waitrequest  (m_waitrequest),
        .m_readdata     (m_readdata),
        .sysid_value    (sysid_value),
        .sysid_timestamp(sysid_timestamp),
        .id_match       (id_match),
        .ts_match       (ts_match),
        .pass           (pass),
        .timeout_err    (timeout_err),
        .busy           (busy),
        .done           (done)
    );

    always #5 clock = ~clock;

    // Predicts one check run, counting edges from the edge that launches the first ID read.
    task automatic predictRun(input logic [31:0] idW, input logic [31:0] tsW, input int sId, input int sTs);
        bit idTo, tsTo, idOk, tsOk;
        int attempts, perPass;
        idTo = (1 + sId + LAT) > TMO;
        tsTo = !idTo && ((1 + sTs + LAT) > TMO);
        if (!idTo) mdlValue = idW;
        if (!idTo && !tsTo) mdlTs = tsW;
        idOk = (mdlValue == EXP_ID);
        tsOk = (mdlTs == EXP_TS);
        attempts = (RETRY && !idTo && !tsTo && !(idOk && tsOk)) ? 1 + MAXR : 1;
        perPass = 3 + sId + sTs + 2 * LAT;
        if (idTo) expDone = TMO + 2;
        else if (tsTo) expDone = 3 + sId + LAT + TMO;
        else expDone = 1 + attempts * perPass;
        expPairs = attempts;
        expStat = {idOk, tsOk, idOk && tsOk && !(idTo || tsTo), idTo || tsTo};
    endtask

    // Plays the sysid slave cycle by cycle until done rises, the abort cycle is reached or the budget runs out.
    task automatic runCheck(input logic [31:0] idW, input logic [31:0] tsW, input int sId, input int sTs,
                            input int busyStartAt, input int abortAt);
        int stallLeft, respAt;
        logic [31:0] respWord;
        bit prevStall, prevAddr, stallNow;
        stallLeft = sId; respAt = -1; respWord = '0; prevStall = 0; prevAddr = 0;
        doneEdge = 0; pairs = 0; viol = 0; lastRead = 0; first = '0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clock); #1;
            start = (c == busyStartAt);
            if (c == 1) first = {done, pass, busy, m_read, m_address};
            if (c == abortAt) begin
                reset = 1'b1;
                m_waitrequest = 1'b0;
                return;
            end
            if (done === 1'b1) begin
                doneEdge = c;
                m_waitrequest = 1'b0;
                return;
            end
            if (prevStall && m_read === 1'b1 && m_address !== prevAddr) viol++;
            if (m_read === 1'b1) lastRead = c;
            stallNow = (m_read === 1'b1) && (stallLeft > 0);
            if (stallNow) stallLeft--;
            m_waitrequest = stallNow;
            prevStall = stallNow;
            prevAddr = m_address;
            if (m_read === 1'b1 && !stallNow) begin
                if (m_address === 1'b0) begin
                    pairs++;
                    respWord = idW;
                    stallLeft = sTs;
                end else begin
                    respWord = tsW;
                    stallLeft = sId;
                end
                respAt = c + LAT;
            end
            m_readdata = (respAt == c) ? respWord : $urandom();
        end
        start = 1'b0;
        m_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        nCompared++;
        if ({m_read, m_address, busy, done, id_match, ts_match, pass, timeout_err} !== 8'h00) begin
            nMismatched++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000000",
                     {m_read, m_address, busy, done, id_match, ts_match, pass, timeout_err});
        end
        nCompared++;
        if ({sysid_value, sysid_timestamp} !== 64'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_words: got %h/%h expected 0/0", sysid_value, sysid_timestamp);
        end
        reset = 1'b0;
        mdlValue = '0;
        mdlTs = '0;
        predictRun(EXP_ID, EXP_TS, 0, 0);
        runCheck(EXP_ID, EXP_TS, 0, 0, 0, 0);
        nCompared++;
        if (first[2:0] !== 3'b110) begin
            nMismatched++;
            $display("[TB] FAIL edge1_read: got busy/read/addr=%b expected 110", first[2:0]);
        end
        nCompared++;
        if (doneEdge != expDone) begin
            nMismatched++;
            $display("[TB] FAIL golden_done_edge: got %0d expected %0d", doneEdge, expDone);
        end
        nCompared++;
        if ({id_match, ts_match, pass, timeout_err} !== expStat || sysid_value !== EXP_ID) begin
            nMismatched++;
            $display("[TB] FAIL golden_status: got %b id=%h expected %b id=%h",
                     {id_match, ts_match, pass, timeout_err}, sysid_value, expStat, EXP_ID);
        end
    endtask

    task automatic test_mismatch();
        start = 1'b1;
        predictRun(32'hDEADBEEF, EXP_TS, 1, 0);
        runCheck(32'hDEADBEEF, EXP_TS, 1, 0, 0, 0);
        nCompared++;
        if ({id_match, ts_match, pass, timeout_err} !== 4'b0100) begin
            nMismatched++;
            $display("[TB] FAIL mismatch_status: got %b expected 0100", {id_match, ts_match, pass, timeout_err});
        end
        nCompared++;
        if (pairs != expPairs) begin
            nMismatched++;
            $display("[TB] FAIL mismatch_read_pairs: got %0d expected %0d", pairs, expPairs);
        end
        nCompared++;
        if (doneEdge != expDone || sysid_value !== 32'hDEADBEEF) begin
            nMismatched++;
            $display("[TB] FAIL mismatch_done: got edge %0d id=%h expected edge %0d id=deadbeef",
                     doneEdge, sysid_value, expDone);
        end
    endtask

    task automatic test_stall();
        start = 1'b1;
        predictRun(EXP_ID, EXP_TS, 5, 0);
        runCheck(EXP_ID, EXP_TS, 5, 0, 0, 0);
        nCompared++;
        if (doneEdge != 13) begin
            nMismatched++;
            $display("[TB] FAIL stall_done_edge: got %0d expected 13", doneEdge);
        end
        nCompared++;
        if (viol != 0) begin
            nMismatched++;
            $display("[TB] FAIL stall_stable: got %0d address changes expected 0", viol);
        end
        nCompared++;
        if ({id_match, ts_match, pass, timeout_err} !== expStat) begin
            nMismatched++;
            $display("[TB] FAIL stall_status: got %b expected %b", {id_match, ts_match, pass, timeout_err}, expStat);
        end
    endtask

    task automatic test_start();
        start = 1'b1;
        predictRun(EXP_ID, EXP_TS, 0, 3);
        runCheck(EXP_ID, EXP_TS, 0, 3, 2, 0);
        nCompared++;
        if (first[4:2] !== 3'b001) begin
            nMismatched++;
            $display("[TB] FAIL start_clears: got done/pass/busy=%b expected 001", first[4:2]);
        end
        nCompared++;
        if (doneEdge != expDone) begin
            nMismatched++;
            $display("[TB] FAIL start_busy_ignored: got done edge %0d expected %0d", doneEdge, expDone);
        end
        nCompared++;
        if ({id_match, ts_match, pass, timeout_err} !== expStat) begin
            nMismatched++;
            $display("[TB] FAIL start_status: got %b expected %b", {id_match, ts_match, pass, timeout_err}, expStat);
        end
    endtask

    task automatic test_timeout();
        start = 1'b1;
        predictRun(32'h11111111, 32'h22222222, 100000, 0);
        runCheck(32'h11111111, 32'h22222222, 100000, 0, 0, 0);
        nCompared++;
        if (lastRead != TMO) begin
            nMismatched++;
            $display("[TB] FAIL timeout_read_drop: got last read edge %0d expected %0d", lastRead, TMO);
        end
        nCompared++;
        if (doneEdge != expDone) begin
            nMismatched++;
            $display("[TB] FAIL timeout_done_edge: got %0d expected %0d", doneEdge, expDone);
        end
        nCompared++;
        if ({id_match, ts_match, pass, timeout_err} !== expStat || sysid_value !== mdlValue) begin
            nMismatched++;
            $display("[TB] FAIL timeout_status: got %b id=%h expected %b id=%h",
                     {id_match, ts_match, pass, timeout_err}, sysid_value, expStat, mdlValue);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        runCheck(EXP_ID, EXP_TS, 0, 0, 0, 5);
        @(posedge clock);
        #1;
        nCompared++;
        if ({m_read, m_address, busy, done, id_match, ts_match, pass, timeout_err} !== 8'h00) begin
            nMismatched++;
            $display("[TB] FAIL midreset_ctrl: got %b expected 00000000",
                     {m_read, m_address, busy, done, id_match, ts_match, pass, timeout_err});
        end
        nCompared++;
        if ({sysid_value, sysid_timestamp} !== 64'h0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_words: got %h/%h expected 0/0", sysid_value, sysid_timestamp);
        end
        reset = 1'b0;
        mdlValue = '0;
        mdlTs = '0;
        predictRun(EXP_ID, EXP_TS, 2, 1);
        runCheck(EXP_ID, EXP_TS, 2, 1, 0, 0);
        nCompared++;
        if (doneEdge != expDone || {id_match, ts_match, pass, timeout_err} !== expStat) begin
            nMismatched++;
            $display("[TB] FAIL midreset_rerun: got edge %0d status %b expected edge %0d status %b",
                     doneEdge, {id_match, ts_match, pass, timeout_err}, expDone, expStat);
        end
    endtask

    task automatic test_random();
        logic [31:0] idW, tsW;
        int sId, sTs;
        for (int n = 0; n < 16; n++) begin
            idW = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom();
            tsW = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom();
            sId = $urandom_range(0, 9);
            sTs = $urandom_range(0, 9);
            start = 1'b1;
            predictRun(idW, tsW, sId, sTs);
            runCheck(idW, tsW, sId, sTs, 0, 0);
            nCompared++;
            if (doneEdge != expDone) begin
                nMismatched++;
                $display("[TB] FAIL random_done_edge[%0d]: got %0d expected %0d (stalls %0d/%0d)",
                         n, doneEdge, expDone, sId, sTs);
            end
            nCompared++;
            if ({id_match, ts_match, pass, timeout_err} !== expStat) begin
                nMismatched++;
                $display("[TB] FAIL random_status[%0d]: got %b expected %b", n,
                         {id_match, ts_match, pass, timeout_err}, expStat);
            end
            nCompared++;
            if (sysid_value !== mdlValue || sysid_timestamp !== mdlTs) begin
                nMismatched++;
                $display("[TB] FAIL random_words[%0d]: got %h/%h expected %h/%h", n,
                         sysid_value, sysid_timestamp, mdlValue, mdlTs);
            end
        end
    endtask

    initial begin
        $display("[TB] sysid checker bench, retry=%0d", RETRY);
        test_reset();
        test_mismatch();
        test_stall();
        test_start();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/first_nios2_system_sysid_checker.md
# first_nios2_system_sysid_checker

Boot-time consumer of the system-ID peripheral. An Avalon-MM read master reads the ID word and timestamp word from the sysid control slave and compares them against build-time expected values. It then presents registered match/pass/error status to the reset sequencer and to a debug LED/CSR bank. It sits directly downstream of the sysid slave on the system interconnect.

## Interface
- EXPECTED_ID, 32'h0, system ID value the hardware must report at word address 0
- EXPECTED_TS, 32'h0, timestamp value the hardware must report at word address 1
- READ_LATENCY, 0, fixed slave read latency in cycles after accept (0..3; 0 = readdata valid in accept cycle)
- TIMEOUT, 255, max cycles from read assertion to data capture before error (1..65535)
- MAX_RETRIES, 3, extra full passes on mismatch (only with retry macro)
- clock  in  1  system clock
- reset  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  one-cycle pulse; re-runs the check when in DONE
- m_address  out  1  word address to sysid slave (0 = ID, 1 = timestamp)
- m_read  out  1  read request
- m_waitrequest  in  1  slave stall; request accepted in a cycle where m_read=1 and m_waitrequest=0
- m_readdata  in  32  slave read data
- sysid_value  out  32  captured ID word
- sysid_timestamp  out  32  captured timestamp word
- id_match, ts_match  out  1 each  captured word equals expected
- pass  out  1  id_match & ts_match & ~timeout_err
- timeout_err  out  1  a read failed to complete within TIMEOUT
- busy  out  1  check in progress
- done  out  1  check complete; status valid

## Operation
- States: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CHECK, DONE.
- Reset: state IDLE with auto-start pending; all outputs 0; captured registers 0; timeout counter 0; retry count 0.
- IDLE -> RD_ID unconditionally on the first edge after reset deasserts.
- RD_ID: m_read=1, m_address=0, held stable until accept. On accept: READ_LATENCY=0 captures m_readdata into sysid_value and goes to RD_TS. Otherwise goes to WAIT_ID.
- WAIT_ID: m_read=0. Counts READ_LATENCY cycles after accept, captures on the last one, then goes to RD_TS.
- RD_TS/WAIT_TS: identical, with m_address=1, capturing into sysid_timestamp. Then goes to CHECK.
- CHECK: one cycle; registers id_match, ts_match and pass; goes to DONE.
- DONE: done=1, busy=0. Status holds until start or reset.
- start in DONE: clears the status outputs and timeout_err, then goes to RD_ID on the next edge. Captured words keep old values until overwritten.
- start in any other state is ignored.
- Timeout counter: 16 bits. Cleared on entry to RD_ID/RD_TS and increments each cycle until capture. Reaching TIMEOUT sets timeout_err, forces m_read=0 and goes to CHECK; the uncaptured word is left unchanged.
- busy=1 in all states except IDLE and DONE.
- Reset mid-transaction abandons the read immediately: m_read=0 on the next edge, no capture. The slave being stateless makes this safe.

## Timing
- With m_waitrequest=0 and READ_LATENCY=0, counting edges after reset deasserts:
  - Edge 1: m_read=1, m_address=0.
  - Edge 2: ID captured, m_address=1.
  - Edge 3: timestamp captured.
  - Edge 4: done=1 with valid status.
- Each waitrequest cycle and each READ_LATENCY cycle adds one cycle per read.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- FIRST_NIOS2_SYSTEM_SYSID_CHECKER_RETRY_EN defined: on a mismatch (not timeout), CHECK returns to RD_ID while retry count < MAX_RETRIES. Retry count increments per retry and clears on start/reset. done rises only after the final attempt.
- Undefined: a mismatch goes straight to DONE; the retry counter is not instantiated and MAX_RETRIES is ignored.

## Test plan
- EXPECTED_ID=32'h52435AF5, EXPECTED_TS=0, slave returns those values with zero wait/latency -> done=1 at edge 4, pass=1, sysid_value=32'h52435AF5.
- Slave returns ID 32'hDEADBEEF -> id_match=0, ts_match=1, pass=0. With retry enabled, 4 read pairs are observed before done.
- m_waitrequest high 5 cycles on the ID read, READ_LATENCY=2 -> m_read/m_address stable while stalled; done at edge 4+5+2+2=13; pass=1.
- m_waitrequest stuck high, TIMEOUT=10 -> timeout_err=1 and m_read drops after 10 stalled cycles, pass=0, done=1.
- reset pulsed while in WAIT_TS -> all outputs 0 next cycle; a fresh pass completes with correct status.
- start pulsed in DONE after a pass -> done and pass drop for the rerun; start pulsed while busy -> no effect.
